// File: rtl/clk_ce_pkg.sv
// clk_ce_pkg: FSM encoding, increment saturation and default channel rates
// shared by the clock-enable generator and its accumulator channels.
package clk_ce_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLDOFF   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    localparam int MAX_ACC_W = 32;

    // Increments for a 56.75 MHz master clock and a 24-bit accumulator.
    localparam logic [23:0] INC_1M77 = 24'h080000;
    localparam logic [23:0] INC_3M5  = 24'h100000;
    localparam logic [23:0] INC_7M   = 24'h200000;
    localparam logic [23:0] INC_14M  = 24'h400000;

    // Half the accumulator range is the fastest rate that still yields distinct ce_p/ce_n cycles.
    function automatic logic [MAX_ACC_W-1:0] sat_inc(input logic [MAX_ACC_W-1:0] inc,
                                                     input int unsigned           w);
        logic [MAX_ACC_W-1:0] half;
        half = MAX_ACC_W'(1) << (w - 1);
        return (inc > half) ? half : inc;
    endfunction

endpackage

// File: rtl/clk_ce_acc.sv
// clk_ce_acc: one phase-accumulator channel with saturation and registered
// rising (carry) and falling (MSB rise) enables.
module clk_ce_acc
    import clk_ce_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             carry_o,
    output logic             ce_p_o,
    output logic             ce_n_o
);

    logic [ACC_W-1:0] acc_q, acc_d, inc_sat;
    logic [ACC_W:0]   sum;
    logic             ce_p_q, ce_n_q, ce_p_d, ce_n_d;

    assign inc_sat = ACC_W'(sat_inc(MAX_ACC_W'(inc_i), ACC_W));
    assign sum     = {1'b0, acc_q} + {1'b0, inc_sat};
    assign carry_o = sum[ACC_W];
    assign acc_d   = clr_i ? '0 : (en_i ? sum[ACC_W-1:0] : acc_q);
    assign ce_p_d  = en_i & sum[ACC_W];
    assign ce_n_d  = en_i & ~sum[ACC_W] & ~acc_q[ACC_W-1] & sum[ACC_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ce_p_q <= 1'b0;
            ce_n_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ce_p_q <= ce_p_d;
            ce_n_q <= ce_n_d;
        end
    end

    assign ce_p_o = ce_p_q;
    assign ce_n_o = ce_n_q;

endmodule

// File: rtl/clk_ce_gen.sv
// clk_ce_gen: multi-channel fractional clock-enable generator gated on PLL lock,
// with frame-aligned increment updates. CLK_CE_PAUSE_EN adds a pause input.
module clk_ce_gen
    import clk_ce_pkg::*;
#(
    parameter int                        CHANNELS  = 3,
    parameter int                        ACC_W     = 24,
    parameter int                        LOCK_WAIT = 1024,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      locked,
    input  logic [CHANNELS*ACC_W-1:0] inc_bus,
    input  logic                      upd_req,
`ifdef CLK_CE_PAUSE_EN
    input  logic                      pause,
`endif
    output logic                      upd_ack,
    output logic [CHANNELS-1:0]       ce_p,
    output logic [CHANNELS-1:0]       ce_n,
    output logic                      ready
);

    localparam int CNT_W = $clog2(LOCK_WAIT + 1);

    logic [1:0]                sync_q;
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*ACC_W-1:0] active_q, active_d, shadow_q, shadow_d;
    logic                      pending_q, pending_d, ack_q, ready_q;
    logic                      lock_s, run_st, acc_en, pause_w, apply, unused_carry;
    logic [CHANNELS-1:0]       carry;

`ifdef CLK_CE_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign lock_s = sync_q[1];
    assign run_st = lock_s && (state_q == ST_RUN);
    assign acc_en = run_st && !pause_w;

    // Switch rates on a channel-0 carry so the new rate starts at a period boundary.
    assign apply     = pending_q && (!acc_en || (active_q[ACC_W-1:0] == '0) || carry[0]);
    assign active_d  = apply ? shadow_q : active_q;
    assign shadow_d  = upd_req ? inc_bus : shadow_q;
    assign pending_d = upd_req || (pending_q && !apply);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
        end else if (state_q == ST_WAIT_LOCK) begin
            state_d = ST_HOLDOFF;
            cnt_d   = CNT_W'(LOCK_WAIT - 1);
        end else if (state_q == ST_HOLDOFF) begin
            state_d = (cnt_q == '0) ? ST_RUN : ST_HOLDOFF;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            active_q  <= INC_INIT;
            shadow_q  <= INC_INIT;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= apply;
            ready_q   <= (state_d == ST_RUN);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_ce_acc #(.ACC_W(ACC_W)) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (acc_en),
            .clr_i  (!run_st),
            .inc_i  (active_q[i*ACC_W +: ACC_W]),
            .carry_o(carry[i]),
            .ce_p_o (ce_p[i]),
            .ce_n_o (ce_n[i])
        );
    end

    assign unused_carry = ^carry;
    assign upd_ack      = ack_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_clk_ce_gen.sv
// tb_clk_ce_gen: randomized bench for clk_ce_gen against a rate/lock-history model,
// plus literal timing pins for the model.
module tb_clk_ce_gen;

    localparam int CH = 3;
    localparam int W  = 24;
    localparam int LW = 16;
    localparam logic [CH*W-1:0] INIT = {24'h0AB123, 24'hFFFFFF, 24'h100000};
    localparam longint FULL = longint'(1) << W;
    localparam longint HALF = longint'(1) << (W - 1);

    logic          clk = 1'b0, rst_n = 1'b0, locked = 1'b0, upd_req = 1'b0;
    logic          upd_ack, ready;
    logic [CH*W-1:0] inc_bus = '0;
    logic [CH-1:0] ce_p, ce_n;
`ifdef CLK_CE_PAUSE_EN
    logic          pause = 1'b0;
`endif

    int total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;

    clk_ce_gen #(.CHANNELS(CH), .ACC_W(W), .LOCK_WAIT(LW), .INC_INIT(INIT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .locked (locked),
        .inc_bus(inc_bus),
        .upd_req(upd_req),
`ifdef CLK_CE_PAUSE_EN
        .pause  (pause),
`endif
        .upd_ack(upd_ack),
        .ce_p   (ce_p),
        .ce_n   (ce_n),
        .ready  (ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: ready follows a run of LW+1 locked samples seen through a 2-cycle lag;
    // each channel advances by its (saturated) increment only while ready stays high.
    longint m_acc[CH], m_act[CH], m_sh[CH];
    longint s;
    bit     m_pend, run, paused, apply, prev_rdy;
    int     rl, dly;
    int     hist[$];
    logic   e_ready = 1'b0, e_ack = 1'b0;
    logic [CH-1:0] e_p = '0, e_n = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; rl = 0; hist.delete(); m_pend = 0;
            e_ready = 1'b0; e_ack = 1'b0; e_p = '0; e_n = '0;
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0;
                m_act[c] = longint'(INIT[c*W +: W]);
                m_sh[c]  = m_act[c];
            end
        end else begin
            cyc++;
            rl = locked ? rl + 1 : 0;
            hist.push_back(rl);
            if (hist.size() > 3) void'(hist.pop_front());
            dly = (hist.size() == 3) ? hist[0] : 0;
            prev_rdy = e_ready;
            e_ready  = dly > LW;
`ifdef CLK_CE_PAUSE_EN
            paused = pause;
`else
            paused = 1'b0;
`endif
            run = prev_rdy && e_ready && !paused;
            for (int c = 0; c < CH; c++) begin
                s = m_acc[c] + ((m_act[c] > HALF) ? HALF : m_act[c]);
                e_p[c] = run && (s >= FULL);
                e_n[c] = run && (s < FULL) && (m_acc[c] < HALF) && (s >= HALF);
                if (run) m_acc[c] = s % FULL;
                else if (!(prev_rdy && e_ready)) m_acc[c] = 0;
            end
            apply = m_pend && (!run || m_act[0] == 0 || e_p[0]);
            e_ack = apply;
            if (apply) for (int c = 0; c < CH; c++) m_act[c] = m_sh[c];
            if (upd_req) begin
                for (int c = 0; c < CH; c++) m_sh[c] = longint'(inc_bus[c*W +: W]);
                m_pend = 1;
            end else if (apply) begin
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", ready, e_ready);
            chk("upd_ack", upd_ack, e_ack);
            chk("ce_p", ce_p, e_p);
            chk("ce_n", ce_n, e_n);
        end
    end

    function automatic bit hit(input int w);
        return w == 0 ? ready : w == 1 ? ce_p[0] : w == 2 ? ce_n[0] : w == 3 ? upd_ack : !ready;
    endfunction

    task automatic wait_ev(input int which, input int lim, input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!hit(which) && t < lim);
        chk(nm, hit(which), 1);
    endtask

    function automatic logic [W-1:0] rnd_inc();
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? '0 : k == 1 ? {W{1'b1}} : W'($urandom_range(32'h8000, 32'h7FFFFF));
    endfunction

    initial begin
        int rdy, p, np, nn, both, acks, drop;
        locked = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ce_p", ce_p, 0);
        chk("rst_ce_n", ce_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ack", upd_ack, 0);
        rst_n = 1'b1;

        wait_ev(0, 100, "wait_ready");
        chk("ready_cycle", cyc, 19);
        rdy = cyc;
        wait_ev(1, 100, "wait_cep0");
        chk("first_cep0", cyc - rdy, 16);
        p = cyc;
        wait_ev(2, 100, "wait_cen0");
        chk("cen0_offset", cyc - p, 8);
        wait_ev(1, 100, "wait_cep0");
        chk("cep0_period", cyc - p, 16);

        np = 0; nn = 0; both = 0;
        repeat (20) begin
            @(negedge clk);
            np += int'(ce_p[1]);
            nn += int'(ce_n[1]);
            both += int'(ce_p[1] & ce_n[1]);
        end
        chk("sat_cep_count", np, 10);
        chk("sat_cen_count", nn, 10);
        chk("sat_overlap", both, 0);

        inc_bus = INIT;
        inc_bus[W-1:0] = 24'h080000;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        wait_ev(3, 100, "wait_ack");
        chk("ack_on_carry", ce_p[0], 1);
        p = cyc;
        wait_ev(1, 100, "wait_cep0");
        chk("slow_period", cyc - p, 32);

        repeat (2) @(negedge clk);
        inc_bus[W-1:0] = 24'h040000;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        repeat (2) @(negedge clk);
        inc_bus[W-1:0] = 24'h200000;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        acks = 0;
        repeat (40) begin
            @(negedge clk);
            acks += int'(upd_ack);
        end
        chk("single_ack", acks, 1);
        wait_ev(1, 100, "wait_cep0");
        p = cyc;
        wait_ev(1, 100, "wait_cep0");
        chk("fast_period", cyc - p, 8);

        locked = 1'b0;
        p = cyc;
        wait_ev(4, 20, "wait_unready");
        chk("drop_latency", cyc - p, 3);
        chk("drop_ce", ce_p | ce_n, 0);
        repeat (7) @(negedge clk);
        locked = 1'b1;
        p = cyc;
        wait_ev(0, 100, "wait_ready");
        chk("relock_ready", cyc - p, 19);
        p = cyc;
        wait_ev(1, 100, "wait_cep0");
        chk("relock_first_cep0", cyc - p, 8);

`ifdef CLK_CE_PAUSE_EN
        repeat (3) @(negedge clk);
        pause = 1'b1;
        np = 0;
        repeat (40) begin
            @(negedge clk);
            np += int'((ce_p | ce_n) != '0);
        end
        pause = 1'b0;
        chk("pause_quiet", np, 0);
        p = cyc;
        wait_ev(1, 100, "wait_cep0");
        chk("pause_resume", cyc - p, 5);
`endif

        drop = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            upd_req = ($urandom_range(0, 29) == 0);
            if (upd_req) for (int c = 0; c < CH; c++) inc_bus[c*W +: W] = rnd_inc();
            if (drop > 0) drop--;
            else if ($urandom_range(0, 599) == 0) drop = $urandom_range(1, 25);
            locked = (drop == 0);
`ifdef CLK_CE_PAUSE_EN
            pause = ($urandom_range(0, 99) < (pause ? 90 : 2));
`endif
        end
        @(negedge clk);
        upd_req = 1'b0;
        locked = 1'b1;
`ifdef CLK_CE_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (50) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ce_gen.md
# clk_ce_gen

Parametrised multi-channel clock-enable generator fed by the core's 56.75 MHz PLL output. It turns the single fast clock into up to CHANNELS independent fractional-rate enable pairs (CPU, AY, ULA, turbo) using phase accumulators. Outputs are gated on PLL lock plus a hold-off. Runtime rate changes are frame-aligned and glitch-free. It sits between the PLL wrapper and every consumer of a derived rate, replacing fixed PLL outputs with runtime-selectable ones.

## Interface
- CHANNELS, 3: number of enable channels (1–8).
- ACC_W, 24: accumulator width; channel rate = f_clk · inc / 2^ACC_W.
- LOCK_WAIT, 1024: clk cycles of hold-off after `locked` rises (≥1).
- INC_INIT, all-zero (CHANNELS·ACC_W bits): increments active after reset; channel k = bits [k·ACC_W +: ACC_W].

Ports:
- clk  in  1  master clock (56.75 MHz PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock, synchronised internally with a 2-flop synchroniser.
- inc_bus  in  CHANNELS·ACC_W  requested increments, sampled on `upd_req`.
- upd_req  in  1  one-cycle strobe: latch `inc_bus` into the shadow register.
- upd_ack  out  1  one-cycle pulse when shadow increments become active.
- ce_p  out  CHANNELS  rising-phase enable, one clk wide.
- ce_n  out  CHANNELS  falling-phase enable, one clk wide, half a period after `ce_p`.
- ready  out  1  high while in RUN.
- pause  in  1  only present with CLK_CE_PAUSE_EN.

## Operation
- FSM states: WAIT_LOCK, HOLDOFF, RUN.
  - WAIT_LOCK → HOLDOFF when the synchronised `locked` is 1. The hold-off counter is loaded with LOCK_WAIT-1.
  - HOLDOFF → RUN when the counter reaches 0.
  - Any state → WAIT_LOCK on synchronised `locked` = 0. Accumulators clear and all `ce_*` are forced to 0 that cycle.
- Accumulator behaviour in RUN, per channel: sum = acc + inc (ACC_W+1 bits), and acc ← sum[ACC_W-1:0].
  - `ce_p` is set when sum[ACC_W] = 1 (carry out).
  - `ce_n` is set when bit ACC_W-1 goes 0→1 without a carry.
- Increment saturation: an effective inc ≥ 2^(ACC_W-1) is saturated to 2^(ACC_W-1). This gives `ce_p` and `ce_n` on alternate cycles. inc = 0 stops the channel with acc held.
- Accumulators are held at 0 outside RUN.
- Update handshake:
  - `upd_req` copies `inc_bus` into the shadow register and sets `pending`.
  - A further `upd_req` while pending overwrites the shadow; only one `upd_ack` is issued.
  - Apply point: the cycle channel 0 produces a carry, or the next cycle if the active inc0 = 0 or the FSM is not in RUN.
  - On apply: active ← shadow, pending clears, and `upd_ack` pulses.
  - Accumulators are not reset on apply, so phase is continuous.
- `upd_req` in the same cycle as an apply: the apply uses the old shadow, and the new request becomes pending.

## Timing
- Reset values: `ce_p` = 0, `ce_n` = 0, `ready` = 0, `upd_ack` = 0, acc = 0, active = shadow = INC_INIT, `pending` = 0, FSM = WAIT_LOCK.
- All outputs are registered.
- `ce_*` asserts in the cycle after the clock edge that computed the carry or MSB rise. Width is exactly 1 clk.
- First `ce_p` after `ready` rises: ceil(2^ACC_W / inc) cycles later.
- `locked` rise → `ready`: 2 (synchroniser) + LOCK_WAIT + 1 cycles.
- `locked` fall → `ce_*` = 0 and `ready` = 0: within 3 cycles.
- `upd_ack` coincides with the first cycle clocked with the new increments.

## Configuration
- CLK_CE_PAUSE_EN defined: adds the `pause` input (synchronous, active-high).
  - While 1, accumulators hold, `ce_p`/`ce_n` are forced to 0, and `ready` stays 1.
  - Pending updates apply immediately regardless of channel 0.
- CLK_CE_PAUSE_EN undefined: no `pause` port. Behaviour as above.

## Structure
- Package `clk_ce_pkg`: FSM state enum, the saturation constant function, and default increment localparams.
  - Example: INC_3M5 = 24'h100000 for 3.546875 MHz at ACC_W = 24.
- Sub-module `clk_ce_acc`: a single channel's accumulator, saturation and `ce_p`/`ce_n` logic. It is instantiated CHANNELS times with a generate loop.
- The top holds the FSM, synchroniser, hold-off counter and shadow/update logic.

## Test plan
- Reset, `locked` = 1 from t0, LOCK_WAIT = 16, INC_INIT ch0 = 24'h100000 → `ready` high at cycle 19; `ce_p[0]` every 16 cycles; `ce_n[0]` 8 cycles after each `ce_p[0]`.
- inc = 24'hFFFFFF (saturated) → `ce_p` and `ce_n` alternate every cycle, never both high together.
- In RUN, `upd_req` with ch0 = 24'h080000 mid-period → `upd_ack` on the next ch0 carry; then `ce_p[0]` every 32 cycles with no extra or missing pulse at the switch.
- Two `upd_req` strobes 3 cycles apart before the apply point → a single `upd_ack`; the second value is active.
- Drop `locked` for 10 cycles in RUN → all `ce_*` = 0 within 3 cycles and `ready` = 0; after relock, hold-off is repeated and accumulators restart from 0.
- With CLK_CE_PAUSE_EN: `pause` = 1 for 40 cycles → no `ce_*` during the pause; phase resumes from the held accumulator value.
